latch_matrix: RTL



---
 rtl/latch_matrix_pkg.sv | 20 ++
 rtl/latch_matrix_if.sv | 22 ++
 rtl/latch_matrix_button_debounce.sv | 48 ++++
 rtl/latch_matrix.sv | 112 +++++++++++
 4 files changed

// File: rtl/latch_matrix_pkg.sv
// Shared types and width helpers for the latch_matrix LED controller.
package latch_matrix_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Timer counts 0..max-1, so clog2(max) bits suffice; never narrower than 1 bit.
  function automatic int timer_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int row_idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/latch_matrix_if.sv
// Switch/button/clear inputs and LED matrix outputs of the latch_matrix controller.
interface latch_matrix_if #(
  parameter int COLS = 8,
  parameter int ROWS = 4
);
  logic [COLS-1:0] switch;
  logic [ROWS-1:0] button;
  logic            clear;
  logic [ROWS-1:0] LEDrow;
  logic [COLS-1:0] LEDcol;
  logic            frame_start;

  modport master (
    output switch, button, clear,
    input  LEDrow, LEDcol, frame_start
  );

  modport slave (
    input  switch, button, clear,
    output LEDrow, LEDcol, frame_start
  );
endinterface

// File: rtl/latch_matrix_button_debounce.sv
// Two-flop synchroniser plus debounce counter for one asynchronous button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  assign w_flip = (r_sync != r_level) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_rise <= w_flip & r_sync;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
endmodule

// File: rtl/latch_matrix.sv
// Switch-latch LED matrix: debounced row capture, row buffers and blanked row scan.
module latch_matrix
  import latch_matrix_pkg::*;
#(
  parameter int              COLS            = 8,
  parameter int              ROWS            = 4,
  parameter int              DWELL_CYCLES    = 100000,
  parameter int              BLANK_CYCLES    = 1000,
  parameter int              DEBOUNCE_CYCLES = 250000,
  parameter logic [COLS-1:0] RESET_PATTERN   = {COLS{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  latch_matrix_if.slave lm
);
  localparam int TW = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam int RW = row_idx_width(ROWS);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  logic [COLS-1:0] r_sw_meta;
  logic [COLS-1:0] r_sw_sync;
  logic [ROWS-1:0] w_db;
  logic [ROWS-1:0] w_rise;
  logic [COLS-1:0] r_row_buf [ROWS];

  scan_state_t     r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [ROWS-1:0] w_sel;

  logic [ROWS-1:0] r_ledrow;
  logic [COLS-1:0] r_ledcol;
  logic            r_frame_start;

  for (genvar g = 0; g < ROWS; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (lm.button[g]),
      .level (w_db[g]),
      .rise  (w_rise[g])
    );
  end

  // Clear takes priority over any capture landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      for (int i = 0; i < ROWS; i++) r_row_buf[i] <= RESET_PATTERN;
    end else begin
      r_sw_meta <= lm.switch;
      r_sw_sync <= r_sw_meta;
      for (int i = 0; i < ROWS; i++) begin
        if (lm.clear)                r_row_buf[i] <= RESET_PATTERN;
        else if (w_rise[i] & w_db[i]) r_row_buf[i] <= r_sw_sync;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_timer_nxt = r_timer + 1'b1;
    case (r_state)
      BLANK: begin
        if (r_timer == BLANK_LAST) begin
          w_state_nxt = DRIVE;
          w_timer_nxt = '0;
        end
      end
      DRIVE: begin
        if (r_timer == DWELL_LAST) begin
          w_state_nxt = BLANK;
          w_timer_nxt = '0;
          w_row_nxt   = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign w_sel = ROWS'(1) << r_row;

  // Outputs are registered from the current scan state, giving LEDcol its one-cycle lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BLANK;
      r_row         <= '0;
      r_timer       <= '0;
      r_ledrow      <= '1;
      r_ledcol      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_timer       <= w_timer_nxt;
      r_ledrow      <= (r_state == DRIVE) ? ~w_sel : '1;
      r_ledcol      <= (r_state == DRIVE) ? r_row_buf[r_row] : '0;
      r_frame_start <= (r_state == DRIVE) && (r_row == '0) && (r_timer == '0);
    end
  end

  assign lm.LEDrow      = r_ledrow;
  assign lm.LEDcol      = r_ledcol;
  assign lm.frame_start = r_frame_start;
endmodule
